// File: rtl/vstore_seq.sv
// vstore_seq: store-side memory sequencer between the vector store unit and
// an AXI-like write port. One store command (base, byte count, id) is split
// into write bursts. Each burst is paired with the operand words the VSU
// presents, write responses are counted, and done_o pulses when every byte
// of the instruction has been acknowledged.
// Optional feature: define VSTORE_SEQ_BOUNDARY_4K_EN to clip bursts so that
// none of them crosses a 4KiB address boundary.
module vstore_seq #(
  parameter int DataWidthB     = 8,
  parameter int AddrWidth      = 32,
  parameter int VlBWidth       = 16,
  parameter int MaxBurstLen    = 8,
  parameter int MaxOutstanding = 4,
  parameter int IdWidth        = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [AddrWidth-1:0]    cmd_addr_i,
  input  logic [VlBWidth-1:0]     cmd_vlb_i,
  input  logic [IdWidth-1:0]      cmd_id_i,
  input  logic                    store_op_valid_i,
  output logic                    store_op_gnt_o,
  input  logic [8*DataWidthB-1:0] store_op_i,
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic [AddrWidth-1:0]    aw_addr_o,
  output logic [7:0]              aw_len_o,
  output logic                    w_valid_o,
  input  logic                    w_ready_i,
  output logic [8*DataWidthB-1:0] w_data_o,
  output logic [DataWidthB-1:0]   w_strb_o,
  output logic                    w_last_o,
  input  logic                    b_valid_i,
  output logic                    b_ready_o,
  output logic                    done_o,
  output logic [IdWidth-1:0]      done_id_o
);

  // Burst length fits 1..256, so 9 bits are needed to hold it.
  localparam int LenW = 9;
  localparam int RbW  = VlBWidth + 1;
  localparam int OutW = $clog2(MaxOutstanding + 1);
  localparam logic [AddrWidth-1:0] AlignMask = AddrWidth'(DataWidthB - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_e;

  state_e               state_q;
  logic [AddrWidth-1:0] addr_q;
  logic [VlBWidth-1:0]  rem_q;
  logic [IdWidth-1:0]   id_q;
  logic [LenW-1:0]      beat_q;
  logic [OutW-1:0]      out_q;
  logic [OutW-1:0]      out_d;
  logic [VlBWidth-1:0]  rem_d;
  logic [VlBWidth-1:0]  step;
  logic [RbW-1:0]       rem_beats;
  logic [LenW-1:0]      burst_len;
  logic                 aw_fire;
  logic                 w_fire;
  logic                 b_fire;
`ifdef VSTORE_SEQ_BOUNDARY_4K_EN
  logic [12:0]          to_4k;
`endif

  // Handshakes and pass-through datapath.
  assign cmd_ready_o    = (state_q == S_IDLE);
  assign aw_valid_o     = (state_q == S_ADDR) && (out_q < OutW'(MaxOutstanding));
  assign aw_fire        = aw_valid_o & aw_ready_i;
  assign aw_addr_o      = addr_q;
  assign aw_len_o       = 8'(burst_len - LenW'(1));
  assign w_valid_o      = (state_q == S_DATA) && store_op_valid_i;
  assign w_fire         = w_valid_o & w_ready_i;
  assign store_op_gnt_o = w_fire;
  assign w_data_o       = store_op_i;
  assign w_last_o       = (state_q == S_DATA) && (beat_q == LenW'(1));
  assign b_ready_o      = (out_q != '0);
  assign b_fire         = b_valid_i & b_ready_o;
  assign done_o         = (state_q == S_RESP) && (rem_q == '0) && (out_d == '0);
  assign done_id_o      = id_q;

  // Next burst length: remaining beats clipped to the burst limit (and 4KiB).
  always_comb begin
    rem_beats = (RbW'(rem_q) + RbW'(DataWidthB - 1)) / RbW'(DataWidthB);
    if (rem_beats > RbW'(MaxBurstLen)) burst_len = LenW'(MaxBurstLen);
    else                               burst_len = LenW'(rem_beats);
`ifdef VSTORE_SEQ_BOUNDARY_4K_EN
    to_4k = (13'd4096 - {1'b0, addr_q[11:0]}) / 13'(DataWidthB);
    if (to_4k < 13'(burst_len)) burst_len = LenW'(to_4k);
`endif
  end

  // Per-beat byte accounting: a short tail beat strobes only its valid bytes.
  always_comb begin
    if (rem_q < VlBWidth'(DataWidthB)) step = rem_q;
    else                               step = VlBWidth'(DataWidthB);
    rem_d    = rem_q - step;
    w_strb_o = '1;
    if (rem_q < VlBWidth'(DataWidthB)) begin
      for (int i = 0; i < DataWidthB; i++) w_strb_o[i] = (VlBWidth'(i) < rem_q);
    end
  end

  // Outstanding-burst count; simultaneous AW and B fires cancel out.
  always_comb begin
    out_d = out_q;
    if (aw_fire && !b_fire)      out_d = out_q + OutW'(1);
    else if (!aw_fire && b_fire) out_d = out_q - OutW'(1);
  end

  // Sequencer FSM: command accept, AW issue, W beats, wait for responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      id_q    <= '0;
      beat_q  <= '0;
      out_q   <= '0;
    end else begin
      out_q <= out_d;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            addr_q <= cmd_addr_i & ~AlignMask;
            rem_q  <= cmd_vlb_i;
            id_q   <= cmd_id_i;
            if (cmd_vlb_i != '0) state_q <= S_ADDR;
            else                 state_q <= S_RESP;
          end
        end
        S_ADDR: begin
          if (aw_fire) begin
            beat_q  <= burst_len;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_fire) begin
            rem_q  <= rem_d;
            addr_q <= addr_q + AddrWidth'(DataWidthB);
            beat_q <= beat_q - LenW'(1);
            if (beat_q == LenW'(1)) begin
              if (rem_d != '0) state_q <= S_ADDR;
              else             state_q <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (done_o) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vstore_seq.sv
// tb_vstore_seq: directed bench for vstore_seq with a transaction-level model
// (expected AW list, expected W beats, outstanding count) checked every cycle.
module tb_vstore_seq;

  localparam int DW  = 8;
  localparam int AW  = 32;
  localparam int VW  = 16;
  localparam int MBL = 8;
  localparam int MO  = 2;
  localparam int IW  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid_i = 1'b0;
  logic            cmd_ready_o;
  logic [AW-1:0]   cmd_addr_i = '0;
  logic [VW-1:0]   cmd_vlb_i = '0;
  logic [IW-1:0]   cmd_id_i = '0;
  logic            store_op_valid_i = 1'b0;
  logic            store_op_gnt_o;
  logic [8*DW-1:0] store_op_i = '0;
  logic            aw_valid_o;
  logic            aw_ready_i = 1'b0;
  logic [AW-1:0]   aw_addr_o;
  logic [7:0]      aw_len_o;
  logic            w_valid_o;
  logic            w_ready_i = 1'b0;
  logic [8*DW-1:0] w_data_o;
  logic [DW-1:0]   w_strb_o;
  logic            w_last_o;
  logic            b_valid_i = 1'b0;
  logic            b_ready_o;
  logic            done_o;
  logic [IW-1:0]   done_id_o;

  vstore_seq #(
    .DataWidthB(DW), .AddrWidth(AW), .VlBWidth(VW),
    .MaxBurstLen(MBL), .MaxOutstanding(MO), .IdWidth(IW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr_i), .cmd_vlb_i(cmd_vlb_i), .cmd_id_i(cmd_id_i),
    .store_op_valid_i(store_op_valid_i), .store_op_gnt_o(store_op_gnt_o),
    .store_op_i(store_op_i),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o),
    .w_strb_o(w_strb_o), .w_last_o(w_last_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
    .done_o(done_o), .done_id_o(done_id_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [7:0] strb; logic last; } beat_t;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // model state
  aw_t         aw_exp[$];
  beat_t       beat_exp[$];
  int          m_out = 0;
  int          m_wauth = 0;
  int          m_widx = 0;
  int          pend_b = 0;
  bit          m_active = 1'b0;
  logic [IW-1:0] m_id = '0;

  // per-instruction logs of observed traffic
  logic [AW-1:0] log_aw_addr[$];
  logic [7:0]    log_aw_len[$];
  logic [7:0]    log_strb[$];
  logic          log_last[$];
  int            log_b = 0;
  int            act_done_cnt = 0;
  int            act_done_cyc = 0;
  int            acc_cyc = 0;
  logic [IW-1:0] last_done_id = '0;

  // stimulus controls
  bit gaps = 1'b0;
  bit b_en = 1'b1;
  bit b_force = 1'b0;

  // monitor scratch
  bit    awf, wf, bf, cf, exp_done;
  int    bl_before;
  aw_t   ea;
  beat_t eb;

  function automatic logic [8*DW-1:0] word_of(input int n);
    return {32'(n) ^ 32'hDEADBEEF, 32'(n) + 32'h0100_0000};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected bursts and beats from the command, by plain arithmetic.
  task automatic plan_cmd(input logic [AW-1:0] addr, input int vlb);
    longint a;
    int rem, beats, nb;
    a = longint'(addr) & ~longint'(DW - 1);
    rem = vlb;
    while (rem > 0) begin
      beats = (rem + DW - 1) / DW;
      if (beats > MBL) beats = MBL;
`ifdef VSTORE_SEQ_BOUNDARY_4K_EN
      if (beats > (4096 - int'(a % 4096)) / DW) beats = (4096 - int'(a % 4096)) / DW;
`endif
      aw_exp.push_back('{addr: AW'(a), len: 8'(beats - 1)});
      for (int k = 0; k < beats; k++) begin
        nb = (rem < DW) ? rem : DW;
        beat_exp.push_back('{strb: 8'((1 << nb) - 1), last: (k == beats - 1)});
        rem -= nb;
        a += DW;
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // input driver: handshake readiness, operand words, B responses
  always @(posedge clk) begin
    #1;
    aw_ready_i       = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
    w_ready_i        = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
    store_op_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
    store_op_i       = word_of(m_widx);
    b_valid_i        = b_force || (b_en && pend_b > 0);
  end

  // compare process: checks every cycle at the falling edge
  always @(negedge clk) begin
    if (done_o) begin
      act_done_cnt++;
      act_done_cyc = cyc;
      last_done_id = done_id_o;
    end
    if (rst) begin
      chk("rst_aw_valid", 64'(aw_valid_o), 64'(0));
      chk("rst_w_valid", 64'(w_valid_o), 64'(0));
      chk("rst_b_ready", 64'(b_ready_o), 64'(0));
      chk("rst_done", 64'(done_o), 64'(0));
      aw_exp.delete();
      beat_exp.delete();
      m_out = 0;
      m_wauth = 0;
      m_active = 1'b0;
      pend_b = 0;
    end else begin
      awf = aw_valid_o && aw_ready_i;
      wf  = w_valid_o && w_ready_i;
      bf  = b_valid_i && b_ready_o;
      cf  = cmd_valid_i && cmd_ready_o;
      bl_before = beat_exp.size();
      chk("cmd_ready", 64'(cmd_ready_o), 64'(!m_active));
      chk("b_ready", 64'(b_ready_o), 64'(m_out > 0));
      if (m_out >= MO || aw_exp.size() == 0) chk("aw_valid_gate", 64'(aw_valid_o), 64'(0));
      if (m_wauth == 0) chk("w_valid_gate", 64'(w_valid_o), 64'(0));
      chk("op_gnt", 64'(store_op_gnt_o), 64'(wf));
      if (wf && m_wauth > 0 && beat_exp.size() > 0) begin
        eb = beat_exp.pop_front();
        chk("w_data", w_data_o, word_of(m_widx));
        chk("w_strb", 64'(w_strb_o), 64'(eb.strb));
        chk("w_last", 64'(w_last_o), 64'(eb.last));
        log_strb.push_back(w_strb_o);
        log_last.push_back(w_last_o);
        m_widx++;
        m_wauth--;
        if (eb.last) pend_b++;
      end
      if (awf) begin
        if (aw_exp.size() > 0) begin
          ea = aw_exp.pop_front();
          chk("aw_addr", 64'(aw_addr_o), 64'(ea.addr));
          chk("aw_len", 64'(aw_len_o), 64'(ea.len));
          m_wauth += int'(ea.len) + 1;
        end
        m_out++;
        log_aw_addr.push_back(aw_addr_o);
        log_aw_len.push_back(aw_len_o);
      end
      if (bf) begin
        if (m_out > 0) m_out--;
        if (pend_b > 0) pend_b--;
        log_b++;
      end
      exp_done = m_active && (bl_before == 0) && (m_out == 0);
      chk("done", 64'(done_o), 64'(exp_done));
      if (exp_done) begin
        chk("done_id", 64'(done_id_o), 64'(m_id));
        m_active = 1'b0;
      end
      if (cf) begin
        m_active = 1'b1;
        m_id = cmd_id_i;
        acc_cyc = cyc;
        log_aw_addr.delete();
        log_aw_len.delete();
        log_strb.delete();
        log_last.delete();
        log_b = 0;
        plan_cmd(cmd_addr_i, int'(cmd_vlb_i));
      end
    end
  end

  task automatic send_cmd(input logic [AW-1:0] a, input int vlb, input logic [IW-1:0] id);
    int t;
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b1;
    cmd_addr_i  = a;
    cmd_vlb_i   = VW'(vlb);
    cmd_id_i    = id;
    t = 0;
    @(negedge clk);
    while (!cmd_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_accept", 64'(cmd_ready_o), 64'(1));
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int start;
    int t;
    start = act_done_cnt;
    t = 0;
    while (act_done_cnt == start && t < budget) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (act_done_cnt == start) begin
      n_err++;
      $display("FAIL %s: no done pulse within %0d cycles, required one", nm, budget);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "time limit");
  end

  initial begin : main
    int snap;
    int t;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", 64'(cmd_ready_o), 64'(1));
    chk("reset_aw_valid", 64'(aw_valid_o), 64'(0));
    chk("reset_done", 64'(done_o), 64'(0));

    // one full burst
    send_cmd(32'h1000, 64, 3'd5);
    wait_done("t1_done", 200);
    chk("t1_aw_cnt", 64'(log_aw_addr.size()), 64'(1));
    if (log_aw_addr.size() >= 1) begin
      chk("t1_aw_addr", 64'(log_aw_addr[0]), 64'h1000);
      chk("t1_aw_len", 64'(log_aw_len[0]), 64'd7);
    end
    chk("t1_beats", 64'(log_strb.size()), 64'(8));
    if (log_strb.size() == 8) begin
      chk("t1_strb0", 64'(log_strb[0]), 64'hFF);
      chk("t1_last6", 64'(log_last[6]), 64'(0));
      chk("t1_last7", 64'(log_last[7]), 64'(1));
    end
    chk("t1_done_id", 64'(last_done_id), 64'(5));

    // short tail beat
    send_cmd(32'h2000, 20, 3'd2);
    wait_done("t2_done", 200);
    chk("t2_aw_cnt", 64'(log_aw_len.size()), 64'(1));
    if (log_aw_len.size() >= 1) chk("t2_aw_len", 64'(log_aw_len[0]), 64'd2);
    chk("t2_beats", 64'(log_strb.size()), 64'(3));
    if (log_strb.size() == 3) begin
      chk("t2_strb0", 64'(log_strb[0]), 64'hFF);
      chk("t2_strb1", 64'(log_strb[1]), 64'hFF);
      chk("t2_strb2", 64'(log_strb[2]), 64'h0F);
      chk("t2_last2", 64'(log_last[2]), 64'(1));
    end
    chk("t2_done_id", 64'(last_done_id), 64'(2));

    // two bursts, done after both responses
    send_cmd(32'h3000, 100, 3'd3);
    wait_done("t3_done", 300);
    chk("t3_aw_cnt", 64'(log_aw_addr.size()), 64'(2));
    if (log_aw_addr.size() >= 2) begin
      chk("t3_aw0_addr", 64'(log_aw_addr[0]), 64'h3000);
      chk("t3_aw0_len", 64'(log_aw_len[0]), 64'd7);
      chk("t3_aw1_addr", 64'(log_aw_addr[1]), 64'h3040);
      chk("t3_aw1_len", 64'(log_aw_len[1]), 64'd4);
    end
    chk("t3_b_cnt", 64'(log_b), 64'(2));
    if (log_strb.size() == 13) chk("t3_strb_tail", 64'(log_strb[12]), 64'h0F);
    else chk("t3_beats", 64'(log_strb.size()), 64'(13));

    // near a 4KiB boundary
    send_cmd(32'h0FF0, 32, 3'd1);
    wait_done("t4_done", 200);
`ifdef VSTORE_SEQ_BOUNDARY_4K_EN
    chk("t4_aw_cnt", 64'(log_aw_addr.size()), 64'(2));
    if (log_aw_addr.size() >= 2) begin
      chk("t4_aw0_addr", 64'(log_aw_addr[0]), 64'h0FF0);
      chk("t4_aw0_len", 64'(log_aw_len[0]), 64'd1);
      chk("t4_aw1_addr", 64'(log_aw_addr[1]), 64'h1000);
      chk("t4_aw1_len", 64'(log_aw_len[1]), 64'd1);
    end
`else
    chk("t4_aw_cnt", 64'(log_aw_addr.size()), 64'(1));
    if (log_aw_addr.size() >= 1) begin
      chk("t4_aw0_addr", 64'(log_aw_addr[0]), 64'h0FF0);
      chk("t4_aw0_len", 64'(log_aw_len[0]), 64'd3);
    end
`endif

    // stray B while nothing outstanding, then a zero-length command
    b_force = 1'b1;
    repeat (4) @(negedge clk);
    b_force = 1'b0;
    send_cmd(32'h4000, 0, 3'd6);
    wait_done("t5_done", 20);
    chk("t5_latency", 64'(act_done_cyc - acc_cyc), 64'(1));
    chk("t5_no_aw", 64'(log_aw_addr.size()), 64'(0));
    chk("t5_no_w", 64'(log_strb.size()), 64'(0));
    chk("t5_done_id", 64'(last_done_id), 64'(6));

    // long store with responses withheld, then released, with random gaps
    gaps = 1'b1;
    b_en = 1'b0;
    send_cmd(32'h8000, 512, 3'd7);
    repeat (300) @(negedge clk);
    chk("t6_aw_held_cnt", 64'(log_aw_addr.size()), 64'(2));
    chk("t6_aw_held_valid", 64'(aw_valid_o), 64'(0));
    chk("t6_beats_before_b", 64'(log_strb.size()), 64'(16));
    b_en = 1'b1;
    wait_done("t6_done", 4000);
    chk("t6_aw_cnt", 64'(log_aw_addr.size()), 64'(8));
    chk("t6_beats", 64'(log_strb.size()), 64'(64));
    chk("t6_b_cnt", 64'(log_b), 64'(8));
    chk("t6_done_id", 64'(last_done_id), 64'(7));
    gaps = 1'b0;

    // reset in the middle of a burst, then a fresh command
    send_cmd(32'h5000, 64, 3'd1);
    t = 0;
    while (log_strb.size() < 3 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("t7_beats_started", 64'(log_strb.size() >= 3), 64'(1));
    snap = act_done_cnt;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t7_no_done", 64'(act_done_cnt - snap), 64'(0));
    send_cmd(32'h6000, 24, 3'd4);
    wait_done("t7_done", 200);
    chk("t7_aw_cnt", 64'(log_aw_addr.size()), 64'(1));
    if (log_aw_addr.size() >= 1) begin
      chk("t7_aw_addr", 64'(log_aw_addr[0]), 64'h6000);
      chk("t7_aw_len", 64'(log_aw_len[0]), 64'd2);
    end
    chk("t7_done_id", 64'(last_done_id), 64'(4));

    repeat (3) @(negedge clk);
    chk("model_drained", 64'(aw_exp.size() + beat_exp.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vstore_seq.md
Name: vstore_seq

Overview:
Store-side memory sequencer downstream of the vector store unit. It accepts one store command (base address, byte count, instruction id) and splits it into AXI-like write bursts. It pairs each burst with the store operand words the VSU presents on its valid/gnt output, and counts write responses. It pulses a done signal to the committer when every byte of the instruction has been acknowledged.

Parameters:
DataWidthB, 8, bytes per store operand word / W beat (power of two)
AddrWidth, 32, memory address width
VlBWidth, 16, width of the byte-count field
MaxBurstLen, 8, maximum beats per AW burst (power of two, 1..256)
MaxOutstanding, 4, maximum AW bursts awaiting B response
IdWidth, 3, instruction id width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
cmd_valid_i  in  1  store command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_addr_i  in  AddrWidth  base byte address, DataWidthB-aligned
cmd_vlb_i  in  VlBWidth  total bytes to store
cmd_id_i  in  IdWidth  instruction id
store_op_valid_i  in  1  VSU operand word valid
store_op_gnt_o  out  1  operand word consumed this cycle
store_op_i  in  8*DataWidthB  operand word
aw_valid_o  out  1  burst address valid
aw_ready_i  in  1  burst address accepted
aw_addr_o  out  AddrWidth  burst start address
aw_len_o  out  8  beats minus one
w_valid_o  out  1  write beat valid
w_ready_i  in  1  write beat accepted
w_data_o  out  8*DataWidthB  write data
w_strb_o  out  DataWidthB  byte strobes
w_last_o  out  1  final beat of burst
b_valid_i  in  1  write response valid
b_ready_o  out  1  write response ready
done_o  out  1  one-cycle pulse: instruction fully acknowledged
done_id_o  out  IdWidth  id of completed instruction

Behaviour:
- Reset (async, rst_i=1): state IDLE; addr, remaining bytes, beat and outstanding counters cleared. All valid outputs and done_o are 0. b_ready_o=0. cmd_ready_o=1 once rst_i deasserts.
- Reset mid-operation aborts the instruction immediately: no done pulse, and no outstanding-count retention.
- States: IDLE, ADDR, DATA, RESP.
- IDLE: cmd_ready_o=1. Accept latches addr, vlb, id.
  - vlb>0 -> ADDR.
  - vlb==0 -> RESP with nothing outstanding.
- ADDR:
  - Burst length L = min(ceil(rem/DataWidthB), MaxBurstLen, beats to 4KiB boundary if the macro is on).
  - aw_valid_o=1 only while outstanding < MaxOutstanding.
  - aw_addr_o = current addr; aw_len_o = L-1.
  - On AW fire: outstanding += 1, beat counter = L -> DATA.
- DATA:
  - w_valid_o = store_op_valid_i; w_data_o = store_op_i (combinational pass-through).
  - store_op_gnt_o = w_valid_o & w_ready_i.
  - w_strb_o = all ones, except when rem < DataWidthB: low rem bits set.
  - w_last_o when beat counter == 1.
  - Each fire: rem -= min(rem, DataWidthB); addr += DataWidthB; beat counter -= 1.
  - After the last-beat fire: rem>0 -> ADDR, else RESP.
- RESP: when rem==0 and outstanding==0 (after any same-cycle decrement), assert done_o for one cycle with done_id_o = latched id, then go to IDLE. cmd_ready_o=0 in the done cycle.
- b_ready_o=1 whenever outstanding>0, in any state. Each B fire decrements outstanding.
- AW fire and B fire in the same cycle leave the count unchanged.
- Outstanding never exceeds MaxOutstanding and never underflows. A B with outstanding==0 is not accepted.
- No AW is issued for zero-length bursts. The address is never misaligned: low log2(DataWidthB) bits of cmd_addr_i are ignored (treated as 0).
- Latency: AW earliest the cycle after command accept; first W the cycle after AW fire.

Optional Feature:
- VSTORE_SEQ_BOUNDARY_4K_EN defined: bursts are additionally clipped so no burst crosses a 4KiB address boundary. Beats to boundary = (4096 - addr[11:0]) / DataWidthB.
- Undefined: bursts are clipped only by MaxBurstLen and remaining bytes.

Test Plan:
- addr 0x1000, vlb 64 -> one AW addr 0x1000 len 7; 8 beats strb 0xFF, w_last on beat 8; after B, done_o one cycle with the command id.
- addr 0x2000, vlb 20 -> AW len 2; strbs 0xFF, 0xFF, 0x0F; w_last on beat 3; done after B.
- addr 0x3000, vlb 100 -> AW 0x3000 len 7, then AW 0x3040 len 4 (last strb 0x0F). done only after both B responses.
- addr 0x0FF0, vlb 32:
  - macro on -> AW 0x0FF0 len 1, then AW 0x1000 len 1.
  - macro off -> single AW 0x0FF0 len 3.
- vlb 512, MaxOutstanding=2, B withheld, random w_ready/store_op_valid gaps:
  - third AW held until a B fires.
  - every operand word consumed exactly once, in order.
- vlb 0 -> no AW/W traffic; done_o the cycle after accept.
- rst_i asserted mid-burst -> valids drop and no done pulse; a new command after reset completes normally.
